// File: rtl/ahb_master_interface.sv
`default_nettype none
// ============================================================================
// Module   : ahb_master_interface
// Brief    : AHB-Lite initiator. Turns a command handshake plus a one-entry
//            write-data buffer into SINGLE or INCR bursts of 32-bit words with
//            overlapped address and data phases, and returns read beats on a
//            pulse interface.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   Hclk, Hreset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (ready only when idle)
//   cmd_write, cmd_addr, cmd_len direction, word-aligned start, beats-1
//   wdata_valid/wdata_ready      write data handshake into one-entry buffer
//   wdata                        write data word
//   rd_valid, rd_data            one-cycle pulse per OKAY read beat
//   done, done_err               one-cycle burst-end pulse, error qualifier
//   Haddr, Htrans, Hwrite,
//   Hsize, Hburst, Hwdata        AHB master outputs (registered)
//   Hreadyin, Hrdata, Hresp      AHB slave responses
// ============================================================================
module ahb_master_interface #(
    parameter int LEN_W = 3
) (
    input  logic             Hclk,
    input  logic             Hreset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wdata_valid,
    input  logic [31:0]      wdata,
    output logic             wdata_ready,
    output logic             rd_valid,
    output logic [31:0]      rd_data,
    output logic             done,
    output logic             done_err,
    output logic [31:0]      Haddr,
    output logic [1:0]       Htrans,
    output logic             Hwrite,
    output logic [2:0]       Hsize,
    output logic [2:0]       Hburst,
    output logic [31:0]      Hwdata,
    input  logic             Hreadyin,
    input  logic [31:0]      Hrdata,
    input  logic [1:0]       Hresp
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ADDR = 2'd1;
    localparam logic [1:0] c_ST_LAST = 2'd2;
    localparam logic [1:0] c_ST_ERR  = 2'd3;

    localparam logic [1:0] c_TR_IDLE   = 2'b00;
    localparam logic [1:0] c_TR_BUSY   = 2'b01;
    localparam logic [1:0] c_TR_NONSEQ = 2'b10;
    localparam logic [1:0] c_TR_SEQ    = 2'b11;

    localparam logic [1:0] c_RESP_OKAY  = 2'b00;
    localparam logic [1:0] c_RESP_ERROR = 2'b01;

    localparam logic [2:0] c_BURST_SINGLE = 3'b000;
    localparam logic [2:0] c_BURST_INCR   = 3'b001;

    // Control state
    logic [1:0]       state_q,     state_d;
    logic [LEN_W-1:0] left_q,      left_d;      // beats still to issue after the pending one
    logic             first_q,     first_d;     // pending beat is the first of the burst
    logic             dphase_q,    dphase_d;    // a data phase is in progress this cycle
    logic             buf_full_q,  buf_full_d;
    logic [31:0]      buf_data_q,  buf_data_d;

    // Registered outputs
    logic [31:0]      Haddr_q,     Haddr_d;
    logic [1:0]       Htrans_q,    Htrans_d;
    logic             Hwrite_q,    Hwrite_d;
    logic [2:0]       Hburst_q,    Hburst_d;
    logic [31:0]      Hwdata_q,    Hwdata_d;
    logic             rd_valid_q,  rd_valid_d;
    logic [31:0]      rd_data_q,   rd_data_d;
    logic             done_q,      done_d;
    logic             done_err_q,  done_err_d;

    logic w_err_cyc;
    logic w_addr_done;
    logic w_drain;
    logic w_fill;
    logic w_beat_ok;

    // An ERROR response seen while a data phase is open; takes precedence
    // over any address phase presented in the same cycle.
    assign w_err_cyc   = dphase_q && (Hresp == c_RESP_ERROR) &&
                         ((state_q == c_ST_ADDR) || (state_q == c_ST_LAST));
    assign w_addr_done = (state_q == c_ST_ADDR) && Hreadyin && Htrans_q[1] && !w_err_cyc;
    assign w_drain     = w_addr_done && Hwrite_q;
    // The buffer may be refilled on the same edge it is drained into Hwdata.
    // During error recovery nothing new is taken since it would be flushed.
    assign wdata_ready = (state_q != c_ST_ERR) && (!buf_full_q || w_drain);
    assign w_fill      = wdata_valid && wdata_ready;

    // A write beat may only be presented once its data sits in the buffer.
    assign w_beat_ok   = !Hwrite_q || buf_full_d;

    always_comb begin
        state_d    = state_q;
        left_d     = left_q;
        first_d    = first_q;
        dphase_d   = dphase_q;
        buf_full_d = (buf_full_q && !w_drain) || w_fill;
        buf_data_d = w_fill ? wdata : buf_data_q;
        Haddr_d    = Haddr_q;
        Htrans_d   = Htrans_q;
        Hwrite_d   = Hwrite_q;
        Hburst_d   = Hburst_q;
        Hwdata_d   = Hwdata_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
        done_err_d = 1'b0;

        case (state_q)
            c_ST_IDLE: begin
                if (cmd_valid) begin
                    state_d  = c_ST_ADDR;
                    left_d   = cmd_len;
                    first_d  = 1'b1;
                    dphase_d = 1'b0;
                    Haddr_d  = cmd_addr;
                    Hwrite_d = cmd_write;
                    Hburst_d = (cmd_len == '0) ? c_BURST_SINGLE : c_BURST_INCR;
                    Htrans_d = (!cmd_write || buf_full_d) ? c_TR_NONSEQ : c_TR_IDLE;
                end
            end

            c_ST_ADDR: begin
                if (w_err_cyc) begin
                    if (Hreadyin) begin
                        state_d    = c_ST_IDLE;
                        Htrans_d   = c_TR_IDLE;
                        dphase_d   = 1'b0;
                        buf_full_d = 1'b0;
                        done_d     = 1'b1;
                        done_err_d = 1'b1;
                    end else begin
                        state_d  = c_ST_ERR;
                        Htrans_d = c_TR_IDLE;
                    end
                end else if (Hreadyin) begin
                    if (dphase_q && !Hwrite_q && (Hresp == c_RESP_OKAY)) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = Hrdata;
                    end
                    if (Htrans_q[1]) begin
                        dphase_d = 1'b1;
                        if (Hwrite_q) begin
                            Hwdata_d = buf_data_q;
                        end
                        if (left_q == '0) begin
                            state_d  = c_ST_LAST;
                            Htrans_d = c_TR_IDLE;
                        end else begin
                            Haddr_d  = Haddr_q + 32'd4;
                            left_d   = left_q - LEN_W'(1);
                            first_d  = 1'b0;
                            Htrans_d = w_beat_ok ? c_TR_SEQ : c_TR_BUSY;
                        end
                    end else begin
                        // Waiting on write data: IDLE/BUSY until it lands.
                        dphase_d = 1'b0;
                        if (w_beat_ok) begin
                            Htrans_d = first_q ? c_TR_NONSEQ : c_TR_SEQ;
                        end
                    end
                end
            end

            c_ST_LAST: begin
                if (w_err_cyc) begin
                    if (Hreadyin) begin
                        state_d    = c_ST_IDLE;
                        dphase_d   = 1'b0;
                        buf_full_d = 1'b0;
                        done_d     = 1'b1;
                        done_err_d = 1'b1;
                    end else begin
                        state_d = c_ST_ERR;
                    end
                end else if (Hreadyin) begin
                    if (!Hwrite_q && (Hresp == c_RESP_OKAY)) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = Hrdata;
                    end
                    state_d  = c_ST_IDLE;
                    dphase_d = 1'b0;
                    done_d   = 1'b1;
                end
            end

            c_ST_ERR: begin
                // Second cycle of the two-cycle ERROR response.
                if (Hreadyin) begin
                    state_d    = c_ST_IDLE;
                    dphase_d   = 1'b0;
                    buf_full_d = 1'b0;
                    done_d     = 1'b1;
                    done_err_d = 1'b1;
                end
            end

            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q    <= c_ST_IDLE;
            left_q     <= '0;
            first_q    <= 1'b0;
            dphase_q   <= 1'b0;
            buf_full_q <= 1'b0;
            buf_data_q <= 32'd0;
            Haddr_q    <= 32'd0;
            Htrans_q   <= c_TR_IDLE;
            Hwrite_q   <= 1'b0;
            Hburst_q   <= c_BURST_SINGLE;
            Hwdata_q   <= 32'd0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'd0;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            left_q     <= left_d;
            first_q    <= first_d;
            dphase_q   <= dphase_d;
            buf_full_q <= buf_full_d;
            buf_data_q <= buf_data_d;
            Haddr_q    <= Haddr_d;
            Htrans_q   <= Htrans_d;
            Hwrite_q   <= Hwrite_d;
            Hburst_q   <= Hburst_d;
            Hwdata_q   <= Hwdata_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            done_q     <= done_d;
            done_err_q <= done_err_d;
        end
    end

    assign cmd_ready = (state_q == c_ST_IDLE);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign done_err  = done_err_q;
    assign Haddr     = Haddr_q;
    assign Htrans    = Htrans_q;
    assign Hwrite    = Hwrite_q;
    assign Hsize     = 3'b010;
    assign Hburst    = Hburst_q;
    assign Hwdata    = Hwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_interface.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_master_interface
// Brief    : Self-checking bench for ahb_master_interface. Cycle vectors for
//            single write, 4-beat read, stalled write and starved write
//            bursts; hand sequences for error abort and mid-burst reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_ahb_master_interface;

    logic        Hclk;
    logic        Hreset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_len;
    logic        wdata_valid;
    logic [31:0] wdata;
    logic        wdata_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic        done_err;
    logic [31:0] Haddr;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic [2:0]  Hsize;
    logic [2:0]  Hburst;
    logic [31:0] Hwdata;
    logic        Hreadyin;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;

    int total = 0;
    int bad   = 0;

    ahb_master_interface #(.LEN_W(3)) dut (
        .Hclk        (Hclk),
        .Hreset      (Hreset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wdata_valid (wdata_valid),
        .wdata       (wdata),
        .wdata_ready (wdata_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .done        (done),
        .done_err    (done_err),
        .Haddr       (Haddr),
        .Htrans      (Htrans),
        .Hwrite      (Hwrite),
        .Hsize       (Hsize),
        .Hburst      (Hburst),
        .Hwdata      (Hwdata),
        .Hreadyin    (Hreadyin),
        .Hrdata      (Hrdata),
        .Hresp       (Hresp)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    typedef struct {
        logic        rst;
        logic        cv;
        logic        cw;
        logic [31:0] ca;
        logic [2:0]  cl;
        logic        wv;
        logic [31:0] wd;
        logic        hr;
        logic [31:0] hrd;
        logic [1:0]  hresp;
        logic        e_cr;
        logic        e_wr;
        logic [1:0]  e_tr;
        logic [31:0] e_ad;
        logic        e_hw;
        logic [2:0]  e_hb;
        logic [31:0] e_wd;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_dn;
        logic        e_de;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic rst, input logic cv, input logic cw, input logic [31:0] ca,
        input logic [2:0] cl, input logic wv, input logic [31:0] wd, input logic hr,
        input logic [31:0] hrd, input logic [1:0] hresp,
        input logic e_cr, input logic e_wr, input logic [1:0] e_tr, input logic [31:0] e_ad,
        input logic e_hw, input logic [2:0] e_hb, input logic [31:0] e_wd,
        input logic e_rv, input logic [31:0] e_rd, input logic e_dn, input logic e_de);
        vec_t t;
        t.rst = rst; t.cv = cv; t.cw = cw; t.ca = ca; t.cl = cl; t.wv = wv; t.wd = wd;
        t.hr = hr; t.hrd = hrd; t.hresp = hresp;
        t.e_cr = e_cr; t.e_wr = e_wr; t.e_tr = e_tr; t.e_ad = e_ad; t.e_hw = e_hw;
        t.e_hb = e_hb; t.e_wd = e_wd; t.e_rv = e_rv; t.e_rd = e_rd; t.e_dn = e_dn; t.e_de = e_de;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cv, input logic cw, input logic [31:0] ca, input logic [2:0] cl,
                         input logic wv, input logic [31:0] wd, input logic hr,
                         input logic [31:0] hrd, input logic [1:0] hresp);
        cmd_valid = cv; cmd_write = cw; cmd_addr = ca; cmd_len = cl;
        wdata_valid = wv; wdata = wd; Hreadyin = hr; Hrdata = hrd; Hresp = hresp;
    endtask

    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    task automatic apply_vec(input vec_t t, input int idx);
        Hreset = t.rst;
        drive(t.cv, t.cw, t.ca, t.cl, t.wv, t.wd, t.hr, t.hrd, t.hresp);
        #1;
        chk($sformatf("v%0d cmd_ready", idx),   {31'd0, cmd_ready},   {31'd0, t.e_cr});
        chk($sformatf("v%0d wdata_ready", idx), {31'd0, wdata_ready}, {31'd0, t.e_wr});
        chk($sformatf("v%0d Htrans", idx),      {30'd0, Htrans},      {30'd0, t.e_tr});
        chk($sformatf("v%0d Haddr", idx),       Haddr,                t.e_ad);
        chk($sformatf("v%0d Hwrite", idx),      {31'd0, Hwrite},      {31'd0, t.e_hw});
        chk($sformatf("v%0d Hburst", idx),      {29'd0, Hburst},      {29'd0, t.e_hb});
        chk($sformatf("v%0d Hwdata", idx),      Hwdata,               t.e_wd);
        chk($sformatf("v%0d rd_valid", idx),    {31'd0, rd_valid},    {31'd0, t.e_rv});
        chk($sformatf("v%0d rd_data", idx),     rd_data,              t.e_rd);
        chk($sformatf("v%0d done", idx),        {31'd0, done},        {31'd0, t.e_dn});
        chk($sformatf("v%0d done_err", idx),    {31'd0, done_err},    {31'd0, t.e_de});
        step();
    endtask

    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] D0 = 32'h1111_0000, D1 = 32'h2222_0000, D2 = 32'h3333_0000, D3 = 32'h4444_0000;
    localparam logic [31:0] E0 = 32'hE000_0000, E1 = 32'hE000_0001, E2 = 32'hE000_0002, E3 = 32'hE000_0003;

    int rv_cnt;

    initial begin
        Hreset = 1'b1;
        drive(0, 0, 32'd0, 3'd0, 0, 32'd0, 1, 32'd0, 2'b00);
        repeat (2) @(posedge Hclk);
        #1;
        Hreset = 1'b0;

        // ---------------- single write (reset state checked in first row)
        //          rst cv cw ca            cl wv wd  hr hrd    resp  | cr wr tr ad            hw hb wd  rv rd     dn de
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 1, DB, 1, 32'h0,  0,   1, 1, 0, 32'h0,        0, 0, 32'h0, 0, 32'h0,  0, 0));
        vecs.push_back(v(0, 1, 1, 32'h8000_0000, 0, 0, 0, 1, 32'h0,  0,   1, 0, 0, 32'h0,        0, 0, 32'h0, 0, 32'h0,  0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 0,  1, 32'h0,  0,   0, 1, 2, 32'h8000_0000, 1, 0, 32'h0, 0, 32'h0,  0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 0,  1, 32'h0,  0,   0, 1, 0, 32'h8000_0000, 1, 0, DB,    0, 32'h0,  0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 0,  1, 32'h0,  0,   1, 1, 0, 32'h8000_0000, 1, 0, DB,    0, 32'h0,  1, 0));
        // ---------------- 4-beat read
        vecs.push_back(v(0, 1, 0, 32'h8400_0000, 3, 0, 0, 1, 32'h0,  0,   1, 1, 0, 32'h8000_0000, 1, 0, DB,    0, 32'h0,  0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 0,  1, 32'h0,  0,   0, 1, 2, 32'h8400_0000, 0, 1, DB,    0, 32'h0,  0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 0,  1, 32'h11, 0,   0, 1, 3, 32'h8400_0004, 0, 1, DB,    0, 32'h0,  0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 0,  1, 32'h22, 0,   0, 1, 3, 32'h8400_0008, 0, 1, DB,    1, 32'h11, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 0,  1, 32'h33, 0,   0, 1, 3, 32'h8400_000C, 0, 1, DB,    1, 32'h22, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 0,  1, 32'h44, 0,   0, 1, 0, 32'h8400_000C, 0, 1, DB,    1, 32'h33, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 0,  1, 32'h0,  0,   1, 1, 0, 32'h8400_000C, 0, 1, DB,    1, 32'h44, 1, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 0,  1, 32'h0,  0,   1, 1, 0, 32'h8400_000C, 0, 1, DB,    0, 32'h44, 0, 0));
        // ---------------- 4-beat write, 2-cycle wait state on beat 2 data phase
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 1, D0, 1, 32'h0,  0,   1, 1, 0, 32'h8400_000C, 0, 1, DB,    0, 32'h44, 0, 0));
        vecs.push_back(v(0, 1, 1, 32'h8C00_0000, 3, 1, D1, 1, 32'h0, 0,   1, 0, 0, 32'h8400_000C, 0, 1, DB,    0, 32'h44, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 1, D1, 1, 32'h0,  0,   0, 1, 2, 32'h8C00_0000, 1, 1, DB,    0, 32'h44, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 1, D2, 1, 32'h0,  0,   0, 1, 3, 32'h8C00_0004, 1, 1, D0,    0, 32'h44, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 1, D3, 0, 32'h0,  0,   0, 0, 3, 32'h8C00_0008, 1, 1, D1,    0, 32'h44, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 1, D3, 0, 32'h0,  0,   0, 0, 3, 32'h8C00_0008, 1, 1, D1,    0, 32'h44, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 1, D3, 1, 32'h0,  0,   0, 1, 3, 32'h8C00_0008, 1, 1, D1,    0, 32'h44, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 0,  1, 32'h0,  0,   0, 1, 3, 32'h8C00_000C, 1, 1, D2,    0, 32'h44, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 0,  1, 32'h0,  0,   0, 1, 0, 32'h8C00_000C, 1, 1, D3,    0, 32'h44, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 0,  1, 32'h0,  0,   1, 1, 0, 32'h8C00_000C, 1, 1, D3,    0, 32'h44, 1, 0));
        // ---------------- 4-beat write, data for beat 3 withheld (BUSY)
        vecs.push_back(v(0, 1, 1, 32'h9000_0000, 3, 1, E0, 1, 32'h0, 0,   1, 1, 0, 32'h8C00_000C, 1, 1, D3,    0, 32'h44, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 1, E1, 1, 32'h0,  0,   0, 1, 2, 32'h9000_0000, 1, 1, D3,    0, 32'h44, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 0,  1, 32'h0,  0,   0, 1, 3, 32'h9000_0004, 1, 1, E0,    0, 32'h44, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 0,  1, 32'h0,  0,   0, 1, 1, 32'h9000_0008, 1, 1, E1,    0, 32'h44, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 1, E2, 1, 32'h0,  0,   0, 1, 1, 32'h9000_0008, 1, 1, E1,    0, 32'h44, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 1, E3, 1, 32'h0,  0,   0, 1, 3, 32'h9000_0008, 1, 1, E1,    0, 32'h44, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 0,  1, 32'h0,  0,   0, 1, 3, 32'h9000_000C, 1, 1, E2,    0, 32'h44, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 0,  1, 32'h0,  0,   0, 1, 0, 32'h9000_000C, 1, 1, E3,    0, 32'h44, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 0,  1, 32'h0,  0,   1, 1, 0, 32'h9000_000C, 1, 1, E3,    0, 32'h44, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i], i);
        end

        // ---------------- 8-beat read, ERROR on beat 3
        rv_cnt = 0;
        drive(1, 0, 32'h8800_0000, 3'd7, 0, 32'd0, 1, 32'd0, 2'b00);
        #1;
        chk("err cmd_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        drive(0, 0, 32'd0, 3'd0, 0, 32'd0, 1, 32'd0, 2'b00);
        #1;
        chk("err nonseq Htrans", {30'd0, Htrans}, 32'd2);
        chk("err nonseq Haddr", Haddr, 32'h8800_0000);
        chk("err Hwrite", {31'd0, Hwrite}, 32'd0);
        chk("err Hburst", {29'd0, Hburst}, 32'd1);
        chk("err Hsize", {29'd0, Hsize}, 32'd2);
        rv_cnt += int'(rd_valid);
        step();
        drive(0, 0, 32'd0, 3'd0, 0, 32'd0, 1, 32'h0000_00A1, 2'b00);
        #1;
        chk("err beat2 Haddr", Haddr, 32'h8800_0004);
        chk("err beat2 Htrans", {30'd0, Htrans}, 32'd3);
        rv_cnt += int'(rd_valid);
        step();
        drive(0, 0, 32'd0, 3'd0, 0, 32'd0, 1, 32'h0000_00A2, 2'b00);
        #1;
        chk("err beat3 Haddr", Haddr, 32'h8800_0008);
        chk("err rd1 data", rd_data, 32'h0000_00A1);
        rv_cnt += int'(rd_valid);
        step();
        drive(0, 0, 32'd0, 3'd0, 0, 32'd0, 0, 32'h0BAD_0BAD, 2'b01);
        #1;
        chk("err first Htrans", {30'd0, Htrans}, 32'd3);
        chk("err first Haddr", Haddr, 32'h8800_000C);
        chk("err rd2 data", rd_data, 32'h0000_00A2);
        rv_cnt += int'(rd_valid);
        step();
        drive(0, 0, 32'd0, 3'd0, 0, 32'd0, 1, 32'h0BAD_0BAD, 2'b01);
        #1;
        chk("err second Htrans", {30'd0, Htrans}, 32'd0);
        chk("err second done", {31'd0, done}, 32'd0);
        chk("err second cmd_ready", {31'd0, cmd_ready}, 32'd0);
        rv_cnt += int'(rd_valid);
        step();
        drive(0, 0, 32'd0, 3'd0, 0, 32'd0, 1, 32'd0, 2'b00);
        #1;
        chk("err done", {31'd0, done}, 32'd1);
        chk("err done_err", {31'd0, done_err}, 32'd1);
        chk("err after cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("err after Htrans", {30'd0, Htrans}, 32'd0);
        rv_cnt += int'(rd_valid);
        step();
        #1;
        chk("err done pulse width", {31'd0, done}, 32'd0);
        rv_cnt += int'(rd_valid);
        chk("err rd_valid count", rv_cnt, 32'd2);

        // ---------------- reset in the middle of a read burst
        drive(1, 0, 32'h8000_0100, 3'd3, 0, 32'd0, 1, 32'd0, 2'b00);
        #1;
        chk("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        drive(0, 0, 32'd0, 3'd0, 1, 32'hF0F0_F0F0, 1, 32'd0, 2'b00);
        #1;
        chk("rst nonseq Htrans", {30'd0, Htrans}, 32'd2);
        chk("rst nonseq Haddr", Haddr, 32'h8000_0100);
        step();
        Hreset = 1'b1;
        drive(0, 0, 32'd0, 3'd0, 0, 32'd0, 1, 32'h7777_7777, 2'b00);
        #1;
        chk("rst seq Haddr", Haddr, 32'h8000_0104);
        step();
        Hreset = 1'b0;
        drive(0, 0, 32'd0, 3'd0, 0, 32'd0, 1, 32'd0, 2'b00);
        #1;
        chk("rst Htrans", {30'd0, Htrans}, 32'd0);
        chk("rst Haddr", Haddr, 32'd0);
        chk("rst Hwrite", {31'd0, Hwrite}, 32'd0);
        chk("rst Hburst", {29'd0, Hburst}, 32'd0);
        chk("rst Hwdata", Hwdata, 32'd0);
        chk("rst rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst rd_data", rd_data, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst done_err", {31'd0, done_err}, 32'd0);
        chk("rst cmd_ready after", {31'd0, cmd_ready}, 32'd1);
        chk("rst wdata_ready", {31'd0, wdata_ready}, 32'd1);
        step();
        drive(0, 0, 32'd0, 3'd0, 1, 32'h5555_AAAA, 1, 32'd0, 2'b00);
        #1;
        chk("rst no done", {31'd0, done}, 32'd0);
        step();
        drive(1, 1, 32'h8000_0200, 3'd0, 0, 32'd0, 1, 32'd0, 2'b00);
        #1;
        chk("post cmd_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        drive(0, 0, 32'd0, 3'd0, 0, 32'd0, 1, 32'd0, 2'b00);
        #1;
        chk("post Htrans", {30'd0, Htrans}, 32'd2);
        chk("post Haddr", Haddr, 32'h8000_0200);
        chk("post Hwrite", {31'd0, Hwrite}, 32'd1);
        chk("post Hburst", {29'd0, Hburst}, 32'd0);
        step();
        #1;
        chk("post idle Htrans", {30'd0, Htrans}, 32'd0);
        chk("post Hwdata", Hwdata, 32'h5555_AAAA);
        step();
        #1;
        chk("post done", {31'd0, done}, 32'd1);
        chk("post done_err", {31'd0, done_err}, 32'd0);
        chk("post cmd_ready idle", {31'd0, cmd_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_master_interface.md
Name: ahb_master_interface

Overview:
- AHB-Lite initiator that drives the bridge's AHB slave port (Haddr, Htrans, Hwrite, Hwdata, Hreadyin) and consumes Hrdata/Hresp.
- Converts simple command/data handshakes into single or INCR bursts of 32-bit words, with pipelined address/data phases.
- Serves as the system-side traffic source and test driver for the AHB-to-APB bridge.

Parameters:
LEN_W, 3, width of cmd_len; burst length is cmd_len+1 beats (1..2^LEN_W).

Ports:
Hclk  in  1  system clock; all logic on rising edge
Hreset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  block idle, can accept a command
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  32  start address, word aligned
cmd_len  in  LEN_W  beats minus one
wdata_valid  in  1  write data word available
wdata  in  32  write data word
wdata_ready  out  1  write buffer empty; wdata taken when valid&ready
rd_valid  out  1  one-cycle pulse, rd_data valid
rd_data  out  32  read data beat
done  out  1  one-cycle pulse at burst end
done_err  out  1  qualifies done: burst ended by ERROR response
Haddr  out  32  AHB address
Htrans  out  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
Hwrite  out  1  transfer direction
Hsize  out  3  constant 3'b010
Hburst  out  3  000 SINGLE if cmd_len==0, else 001 INCR
Hwdata  out  32  write data, driven during data phase
Hreadyin  in  1  slave ready; 1 completes current data phase
Hrdata  in  32  read data
Hresp  in  2  00 OKAY, 01 ERROR

Behaviour:
- Reset, and the cycle after Hreset: Htrans=00, Haddr=0, Hwrite=0, Hburst=0, Hwdata=0, rd_valid=0, rd_data=0, done=0, done_err=0, write buffer empty. cmd_ready=1 after reset.
- Reset mid-burst aborts immediately. No done pulse is generated. Htrans is IDLE on the next cycle.
- All AHB outputs are registered.
- States:
  - IDLE: cmd_ready=1. Command accepted on cmd_valid&cmd_ready. The command is latched, the beat counter is loaded with cmd_len, and the block moves to ADDR.
  - ADDR: issues address phases.
    - First beat uses NONSEQ, later beats use SEQ.
    - Haddr increments by 4 per accepted address phase. 32-bit wrap: FFFF_FFFC -> 0000_0000.
    - An address phase completes on an edge with Hreadyin=1.
  - LAST: final data phase, with Htrans=IDLE.
  - ERR: error recovery (see error handling).
- Address/data overlap:
  - Address phase of beat n+1 coincides with data phase of beat n.
  - While Hreadyin=0, Haddr, Htrans, Hwrite, Hburst and Hwdata are held unchanged.
- Write data path:
  - One-entry buffer; wdata_ready = buffer empty. A simultaneous fill and drain is allowed.
  - A write address phase is issued only when the buffer holds that beat's data.
  - On address-phase completion, buffer contents move to Hwdata for the following data phase.
  - Buffer empty when the next beat is due: drive IDLE before the first beat, BUSY mid-burst. Haddr holds the next beat address; Htrans switches to SEQ once data arrives.
- Reads: on each edge where a read data phase completes with Hreadyin=1 and Hresp=00, rd_data<=Hrdata and rd_valid=1 for one cycle.
- Completion: the last data phase completes with OKAY -> done=1, done_err=0 for one cycle; the block returns to IDLE and cmd_ready=1 on the following cycle.
- Error handling:
  - Hresp=01 with Hreadyin=0 (first error cycle): Htrans=IDLE on the next cycle, cancelling any pending address phase, and remaining beats are dropped.
  - When Hreadyin=1 arrives: done=1, done_err=1, state IDLE.
  - No rd_valid for the errored beat.
  - After an aborted write burst, the write buffer is flushed.
- cmd_valid while busy is ignored (cmd_ready=0). Back-to-back commands: the earliest new NONSEQ appears 1 cycle after done.

Test Plan:
1. Single write, Hreadyin=1: cmd addr 8000_0000, len 0, wdata DEADBEEF pre-supplied -> NONSEQ@8000_0000, Hburst=000, Hwdata=DEADBEEF next cycle, done pulse, done_err=0.
2. 4-beat read, addr 8400_0000, slave returns 11,22,33,44 -> Htrans NONSEQ,SEQ,SEQ,SEQ with Haddr 8400_0000/04/08/0C; rd_valid 4 pulses with rd_data 11,22,33,44 in order; done once.
3. Write burst len 3 with Hreadyin=0 for 2 cycles on beat 2 -> all AHB outputs frozen those 2 cycles; Hwdata sequence correct; done after 4th beat.
4. Write burst, wdata_valid withheld before beat 3 -> Htrans=BUSY with Haddr=base+8 until data arrives, then SEQ; no beat skipped or duplicated.
5. Read burst len 7 at 8800_0000, slave returns ERROR on beat 3 (two-cycle response) -> Htrans=IDLE in second error cycle; only 2 rd_valid pulses; done=1, done_err=1; cmd_ready=1 next cycle.
6. Hreset asserted mid-burst -> next cycle Htrans=00, outputs at reset values, no done; a new command afterwards completes normally.
